// File: rtl/serial_2a1_pkg.sv
// Shared constants and serializer state encoding for the
// 2-bit word FIFO / serializer that follows the 2:1 mux stage.
package serial_2a1_pkg;

    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_AW         = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_MSB = 2'd1,
        SEND_LSB = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_sync_2b.sv
// Synchronous FIFO of 2-bit words: storage, wrapping pointers,
// occupancy count and full/almost-full flags.
module fifo_sync_2b
    import serial_2a1_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int PW    = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [1:0]    i_wdata,
    output logic [1:0]    o_head,
    output logic [PW:0]   o_count,
    output logic          o_full,
    output logic          o_almost_full
);

    logic [1:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Contents need no reset: a slot is only read after being written.
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_head        = r_mem[r_rd_ptr];
    assign o_count       = r_count;
    assign o_full        = (r_count == (PW+1)'(DEPTH));
    assign o_almost_full = (r_count >= (PW+1)'(DEPTH - 1));

endmodule

// File: rtl/serial_2a1_fifo.sv
// Buffers the mux's 2-bit word stream and serializes each word
// MSB-first; flags fullness and sticky overflow (no backpressure).
module serial_2a1_fifo
    import serial_2a1_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AW         = DEF_AW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  logic [1:0] data_in,
    output logic       serial_out,
    output logic       valid_out,
    output logic       fifo_full,
    output logic       almost_full,
    output logic       overflow_err
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_hold;
    logic [1:0]  w_hold_nxt;
    logic        r_serial;
    logic        w_serial_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        r_ovf;

    logic [1:0]  w_head;
    logic [AW:0] w_count;
    logic        w_full;
    logic        w_afull;
    logic        w_pop;
    logic        w_push;

    assign w_pop  = ((r_state == IDLE) || (r_state == SEND_LSB))
                    && (w_count != '0);
    // A full FIFO still takes a word when a slot frees on the same edge.
    assign w_push = valid_in && (!w_full || w_pop);

    fifo_sync_2b #(
        .DEPTH (FIFO_DEPTH),
        .PW    (AW)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_push),
        .i_pop         (w_pop),
        .i_wdata       (data_in),
        .o_head        (w_head),
        .o_count       (w_count),
        .o_full        (w_full),
        .o_almost_full (w_afull)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold;
        w_serial_nxt = 1'b0;
        w_valid_nxt  = 1'b0;
        if (w_pop) begin
            w_hold_nxt   = w_head;
            w_serial_nxt = w_head[1];
            w_valid_nxt  = 1'b1;
            w_state_nxt  = SEND_MSB;
        end else if (r_state == SEND_MSB) begin
            w_serial_nxt = r_hold[0];
            w_valid_nxt  = 1'b1;
            w_state_nxt  = SEND_LSB;
        end else begin
            w_state_nxt  = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_hold   <= 2'b00;
            r_serial <= 1'b0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            r_serial <= w_serial_nxt;
            r_valid  <= w_valid_nxt;
            if (valid_in && !w_push)
                r_ovf <= 1'b1;
        end
    end

    assign serial_out   = r_serial;
    assign valid_out    = r_valid;
    assign fifo_full    = w_full;
    assign almost_full  = w_afull;
    assign overflow_err = r_ovf;

endmodule

// File: doc/serial_2a1_fifo.md
Name: serial_2a1_fifo

Overview:
- Downstream consumer of the 2:1 two-bit mux stage: accepts the mux's validated 2-bit word stream, buffers it in a small synchronous FIFO and serializes each word MSB-first, one bit per clock.
- Absorbs the rate mismatch between the mux (up to 2 bits/cycle) and the serial lane (1 bit/cycle).
- Reports fullness and sticky overflow, because the mux stage has no backpressure.

Parameters:
- FIFO_DEPTH, 4, number of 2-bit entries; power of two, >= 2.
- AW, 2, pointer width = log2(FIFO_DEPTH); count register is AW+1 bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  data_in qualifier (connects to mux validout).
- data_in  input  2  word from mux; may be X when valid_in=0; must be ignored then.
- serial_out  output  1  registered serial bit; bit1 of a word, then bit0.
- valid_out  output  1  registered; 1 while serial_out carries a payload bit.
- fifo_full  output  1  combinational from count: count==FIFO_DEPTH.
- almost_full  output  1  combinational: count>=FIFO_DEPTH-1.
- overflow_err  output  1  sticky: set when a valid word is dropped; cleared only by reset.

Behaviour:
- Reset: synchronous, active-high. When reset=1 at an edge: count=0, wr/rd pointers=0, state=IDLE, serial_out=0, valid_out=0, overflow_err=0, hold register=0. Applies mid-word as well: FIFO contents and the word in flight are discarded. The first edge after reset deasserts can already accept a push.
- Serializer FSM. States: IDLE, SEND_MSB, SEND_LSB. The state after an edge names what serial_out currently holds.
- pop = (state==IDLE or state==SEND_LSB) and count>0, with count taken before the edge.
- On pop: hold<=head; serial_out<=head[1]; valid_out<=1; state<=SEND_MSB; rd_ptr increments.
- In SEND_MSB: serial_out<=hold[0]; valid_out<=1; state<=SEND_LSB. No pop in this state.
- In IDLE or SEND_LSB with count==0: serial_out<=0; valid_out<=0; state<=IDLE.
- Latency: a word sampled at edge N into an empty, idle block shows its MSB after edge N+1 and its LSB after edge N+2.
- Back-to-back words give a gap-free stream: SEND_LSB goes directly to SEND_MSB.
- push = valid_in and (count<FIFO_DEPTH or pop). A push is accepted while full if a pop happens on the same edge.
- valid_in=1 with push=0 drops the word; overflow_err<=1 at that edge.
- Next count = count + push - pop. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop on an empty FIFO is impossible, because pop requires count>0. There is no write-through bypass.
- valid_in=0 leaves FIFO state unchanged, whatever data_in is (X-safe).

Decomposition:
- Package serial_2a1_pkg holds the state encodings (IDLE=2'd0, SEND_MSB=2'd1, SEND_LSB=2'd2) and the default FIFO_DEPTH/AW constants.
- Sub-module fifo_sync_2b holds the storage array, pointers, count and full/almost_full logic. It takes push/pop strobes and exposes head data.
- The top level holds the FSM, the hold register and the overflow flag.

Test Plan:
1. Reset, then one word 2'b10 at edge 1 -> after edge 2: serial_out=1, valid_out=1; after edge 3: serial_out=0, valid_out=1; after edge 4: valid_out=0, serial_out=0.
2. valid_in=1 every other cycle with words 01,11,00 -> serial stream 0,1,1,1,0,0 with valid_out continuously 1 for 6 cycles; no overflow_err.
3. valid_in=1 on every edge 1..9 with words w0..w8, DEPTH=4 -> count after edges 1..8 = 1,1,2,2,3,3,4,4. fifo_full=1 after edge 7. At edge 8 push is accepted with a simultaneous pop. w8 is dropped at edge 9 and overflow_err=1. Serial output later shows w0..w7 in order, never w8.
4. valid_in=0 with data_in=2'bxx for 10 cycles after reset -> valid_out=0, serial_out=0, count=0, no X on outputs.
5. Fill 3 words, assert reset for one edge while state=SEND_MSB -> next cycle all outputs are 0 and count=0. A new word 2'b01 afterwards gives serial 0 then 1.
6. Once overflow_err=1, drain the FIFO and idle 20 cycles -> overflow_err stays 1 until reset.
